tree_result_collector: RTL and testbench
========================================

# tree_result_collector

Terminal stage of the two-lane tree lookup pipeline. It receives the per-lane results that leave the last tree level: packet header, node word, matched flag and valid. Those results are merged in arrival order into one shared FIFO. The FIFO presents them one per cycle on a valid/ready result port toward the action/egress logic. The tree pipeline cannot stall, so overflow is handled by dropping results and counting the drops.

## Interface
Parameters:
- PACKET_WIDTH, 104, packet header width
- NODE_WIDTH, 40, node word width
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 4
- CNT_WIDTH, 16, drop counter width

Ports:
- clk  in  1  single clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- packet_in1  in  PACKET_WIDTH  lane 1 packet from last tree level
- data_valid_in1  in  1  lane 1 result valid
- node_in1  in  NODE_WIDTH  lane 1 final node word
- matched_in1  in  1  lane 1 rule matched
- packet_in2, data_valid_in2, node_in2, matched_in2  in  same widths as lane 1  lane 2 equivalents
- res_packet  out  PACKET_WIDTH  head result packet
- res_node  out  NODE_WIDTH  head result node word
- res_matched  out  1  head result matched flag
- res_lane  out  1  source lane of head result: 0 = lane 1, 1 = lane 2
- res_valid  out  1  head result present
- res_ready  in  1  consumer accepts head result
- fifo_count  out  clog2(FIFO_DEPTH)+1  entries currently stored
- fifo_full  out  1  fifo_count == FIFO_DEPTH
- fifo_empty  out  1  fifo_count == 0
- drop_count  out  CNT_WIDTH  results discarded due to overflow; saturating

## Operation
- Storage: FIFO_DEPTH entries, each {packet, node, matched, lane}.
- Pointers: write pointer, read pointer and registered count. Pointers wrap modulo FIFO_DEPTH.
- Qualification: a lane offers an entry only when its data_valid_in is 1. Unmatched results are stored like matched ones, with matched = 0.
- Pop: occurs when res_valid && res_ready in a cycle.
- Free space per cycle: free = FIFO_DEPTH - fifo_count + pop.
- Write priority:
  - Lane 1 is always written before lane 2 in the same cycle.
  - If only lane 2 is valid, it takes the first slot.
- Write decision:
  - If the number of offered entries is at most free, write all offered entries. The write pointer advances by 0, 1 or 2.
  - If both lanes are valid and free == 1, write lane 1 and drop lane 2.
  - If free == 0, drop all offered entries.
- drop_count update: add the number of dropped entries (0, 1 or 2). Saturate at all-ones; never wrap.
- Count update: fifo_count_next = fifo_count + writes - pop.
- Head presentation: res_* show the entry at the read pointer.
  - res_valid = !fifo_empty.
  - When res_valid = 0, res_packet, res_node, res_matched and res_lane are driven to 0.
- Holding: the head stays stable while res_valid = 1 and res_ready = 0.
- res_ready asserted while empty has no effect.

## Timing
- Reset: while RST = 1, asynchronously and immediately:
  - pointers and fifo_count = 0
  - fifo_empty = 1, fifo_full = 0, res_valid = 0
  - res_packet, res_node, res_matched, res_lane = 0
  - drop_count = 0
  - Stored entries are discarded.
  - Reset mid-operation loses all queued results. This is not counted as drops.
- Latency:
  - A result sampled at rising edge k into an empty FIFO appears on res_* immediately after edge k.
  - It can be popped at edge k+1. There is no bypass in the same cycle.
- Throughput:
  - Up to 2 writes and 1 read per cycle.
  - Sustained dual-lane traffic fills the FIFO at one entry per cycle net.
- Simultaneous events:
  - Pop and write in the same cycle are both performed.
  - A full FIFO with a pop accepts exactly one entry.
- All outputs except the zero-gated res_* fields are registered or decoded directly from registers. No combinational path exists from the inputs to the outputs, except res_ready, which affects only the next-state logic.

## Test plan
- Reset: drive RST = 1 with traffic on both lanes. Required: res_valid = 0, fifo_empty = 1, fifo_count = 0, drop_count = 0, all res_* = 0. After release with no traffic, outputs remain unchanged.
- Single result:
  - Stimulus: packet_in1 = 104'h0A0B...01, node_in1 = 40'h12_3456_7890, matched_in1 = 1, valid for one cycle, res_ready = 1.
  - Required: one cycle later res_valid = 1 with identical fields and res_lane = 0. One cycle after that, fifo_empty = 1.
- Dual arrival ordering:
  - Stimulus: both lanes valid in one cycle with distinct packets P1 and P2, res_ready = 0.
  - Required: fifo_count = 2. With res_ready then raised, the head shows P1 (lane 0) then P2 (lane 1) on consecutive cycles.
- Partial overflow:
  - Stimulus: prefill 7 entries with res_ready = 0, then both lanes valid once.
  - Required: lane 1 stored, fifo_count = 8, fifo_full = 1, drop_count = 1.
- Full with pop:
  - Stimulus: FIFO full, res_ready = 1, both lanes valid for 3 cycles.
  - Required: fifo_count stays 8, drop_count increases by 3. Popped order matches insertion order.
- Reset mid-operation and saturation:
  - Stimulus: with fifo_count = 5, pulse RST.
  - Required: fifo_empty = 1 asynchronously and drop_count = 0.
  - Saturation check: with CNT_WIDTH = 2, force 5 drops. drop_count holds at 3.

Source files
------------

// File: rtl/tree_result_collector.sv
// Merges the two lane results from the last tree level into one FIFO and presents them in arrival
// order on a valid/ready port. The tree cannot stall, so entries that do not fit are dropped and counted.
module tree_result_collector #(
    parameter int PACKET_WIDTH = 104,
    parameter int NODE_WIDTH   = 40,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          RST,
    input  logic [PACKET_WIDTH-1:0]       packet_in1,
    input  logic                          data_valid_in1,
    input  logic [NODE_WIDTH-1:0]         node_in1,
    input  logic                          matched_in1,
    input  logic [PACKET_WIDTH-1:0]       packet_in2,
    input  logic                          data_valid_in2,
    input  logic [NODE_WIDTH-1:0]         node_in2,
    input  logic                          matched_in2,
    output logic [PACKET_WIDTH-1:0]       res_packet,
    output logic [NODE_WIDTH-1:0]         res_node,
    output logic                          res_matched,
    output logic                          res_lane,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [CNT_WIDTH-1:0]          drop_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = PACKET_WIDTH + NODE_WIDTH + 2;

    logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]       count_reg, count_next;
    logic [CNT_WIDTH-1:0] drop_reg, drop_next;
    logic [CNT_WIDTH:0]   drop_sum;
    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];

    logic                 pop;
    logic [PTR_W+1:0]     free;
    logic [1:0]           offered, writes, drops;
    logic                 wr0_en, wr1_en;
    logic [ENTRY_W-1:0]   entry1, entry2, slot0_data, head;
    logic [PTR_W-1:0]     wr_ptr_plus1;
    logic [FIFO_DEPTH-1:0] we0, we1;

    // Entry layout: {packet, node, matched, lane}
    assign entry1       = {packet_in1, node_in1, matched_in1, 1'b0};
    assign entry2       = {packet_in2, node_in2, matched_in2, 1'b1};
    assign slot0_data   = data_valid_in1 ? entry1 : entry2;
    assign wr_ptr_plus1 = wr_ptr_reg + 1'b1;

    assign pop     = (count_reg != '0) && res_ready;
    assign free    = (PTR_W+2)'(FIFO_DEPTH) - {1'b0, count_reg} + {{(PTR_W+1){1'b0}}, pop};
    assign offered = {1'b0, data_valid_in1} + {1'b0, data_valid_in2};

    // Slot 0 takes the first valid lane, slot 1 only ever takes lane 2 behind lane 1.
    always_comb begin
        wr0_en = 1'b0;
        wr1_en = 1'b0;
        if (free >= (PTR_W+2)'(2)) begin
            wr0_en = data_valid_in1 | data_valid_in2;
            wr1_en = data_valid_in1 & data_valid_in2;
        end else if (free == (PTR_W+2)'(1)) begin
            wr0_en = data_valid_in1 | data_valid_in2;
        end
    end

    assign writes = {1'b0, wr0_en} + {1'b0, wr1_en};
    assign drops  = offered - writes;

    always_comb begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(writes);
        rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
        count_next  = count_reg + (PTR_W+1)'(writes) - (PTR_W+1)'(pop);
        drop_sum    = {1'b0, drop_reg} + (CNT_WIDTH+1)'(drops);
        drop_next   = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            drop_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            drop_reg   <= drop_next;
        end
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_we
        assign we0[gi] = wr0_en && (wr_ptr_reg == PTR_W'(gi));
        assign we1[gi] = wr1_en && (wr_ptr_plus1 == PTR_W'(gi));
    end

    // Storage needs no reset: the zeroed count makes old contents unreachable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (we0[i]) begin
                mem[i] <= slot0_data;
            end else if (we1[i]) begin
                mem[i] <= entry2;
            end
        end
    end

    assign head       = mem[rd_ptr_reg];
    assign res_valid  = (count_reg != '0);
    assign {res_packet, res_node, res_matched, res_lane} = res_valid ? head : '0;
    assign fifo_count = count_reg;
    assign fifo_full  = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign drop_count = drop_reg;

endmodule

// File: tb/tb_tree_result_collector.sv
// Scoreboard bench: stimulus pushes the hand-expected stored entries, a monitor pops and compares on each accept.
module tb_tree_result_collector;

    localparam int PW = 104;
    localparam int NW = 40;
    localparam int EW = PW + NW + 2;

    logic clk = 1'b0;
    logic RST = 1'b1;

    logic [PW-1:0] packet_in1 = '0, packet_in2 = '0;
    logic [NW-1:0] node_in1 = '0, node_in2 = '0;
    logic          data_valid_in1 = 1'b0, data_valid_in2 = 1'b0;
    logic          matched_in1 = 1'b0, matched_in2 = 1'b0;
    logic [PW-1:0] res_packet;
    logic [NW-1:0] res_node;
    logic          res_matched, res_lane, res_valid;
    logic          res_ready = 1'b0;
    logic [3:0]    fifo_count;
    logic          fifo_full, fifo_empty;
    logic [15:0]   drop_count;

    // Second instance: shallow FIFO with a 2-bit drop counter for saturation
    logic [PW-1:0] b_packet_in1 = '0, b_packet_in2 = '0;
    logic [NW-1:0] b_node_in1 = '0, b_node_in2 = '0;
    logic          b_valid1 = 1'b0, b_valid2 = 1'b0;
    logic [PW-1:0] b_res_packet;
    logic [NW-1:0] b_res_node;
    logic          b_res_matched, b_res_lane, b_res_valid;
    logic [2:0]    b_fifo_count;
    logic          b_fifo_full, b_fifo_empty;
    logic [1:0]    b_drop_count;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    tree_result_collector dut (
        .clk(clk), .RST(RST),
        .packet_in1(packet_in1), .data_valid_in1(data_valid_in1), .node_in1(node_in1), .matched_in1(matched_in1),
        .packet_in2(packet_in2), .data_valid_in2(data_valid_in2), .node_in2(node_in2), .matched_in2(matched_in2),
        .res_packet(res_packet), .res_node(res_node), .res_matched(res_matched), .res_lane(res_lane),
        .res_valid(res_valid), .res_ready(res_ready),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .drop_count(drop_count)
    );

    tree_result_collector #(.FIFO_DEPTH(4), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .RST(RST),
        .packet_in1(b_packet_in1), .data_valid_in1(b_valid1), .node_in1(b_node_in1), .matched_in1(1'b1),
        .packet_in2(b_packet_in2), .data_valid_in2(b_valid2), .node_in2(b_node_in2), .matched_in2(1'b0),
        .res_packet(b_res_packet), .res_node(b_res_node), .res_matched(b_res_matched), .res_lane(b_res_lane),
        .res_valid(b_res_valid), .res_ready(1'b0),
        .fifo_count(b_fifo_count), .fifo_full(b_fifo_full), .fifo_empty(b_fifo_empty), .drop_count(b_drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] mk(input logic [PW-1:0] p, input logic [NW-1:0] n,
                                         input logic m, input logic lane);
        return {p, n, m, lane};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v1, input logic [PW-1:0] p1, input logic [NW-1:0] n1, input logic m1,
                           input logic v2, input logic [PW-1:0] p2, input logic [NW-1:0] n2, input logic m2);
        data_valid_in1 = v1; packet_in1 = p1; node_in1 = n1; matched_in1 = m1;
        data_valid_in2 = v2; packet_in2 = p2; node_in2 = n2; matched_in2 = m2;
        cyc();
        data_valid_in1 = 1'b0;
        data_valid_in2 = 1'b0;
    endtask

    task automatic drive_b(input logic v1, input logic v2, input logic [7:0] tag);
        b_valid1 = v1; b_packet_in1 = {96'hB1, tag}; b_node_in1 = {32'h0, tag};
        b_valid2 = v2; b_packet_in2 = {96'hB2, tag}; b_node_in2 = {32'h1, tag};
        cyc();
        b_valid1 = 1'b0;
        b_valid2 = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_fifo_empty"}, fifo_empty, 1);
        chk({tag, "_fifo_full"}, fifo_full, 0);
        chk({tag, "_fifo_count"}, fifo_count, 0);
        chk({tag, "_drop_count"}, drop_count, 0);
        chk({tag, "_res_fields"}, {res_packet, res_node, res_matched, res_lane}, 0);
    endtask

    // Monitor: each accepted head must match the oldest expected entry
    always @(negedge clk) begin
        if (!RST && res_valid && res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected actual=%0h required=none", {res_packet, res_node, res_matched, res_lane});
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                $display("POP lane=%0d matched=%0d packet=%0h node=%0h", res_lane, res_matched, res_packet, res_node);
                if ({res_packet, res_node, res_matched, res_lane} !== e) begin
                    errors++;
                    $display("FAIL pop_order actual=%0h required=%0h", {res_packet, res_node, res_matched, res_lane}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PW-1:0] p;
        logic [NW-1:0] n;

        // Reset held with traffic on both lanes
        res_ready = 1'b1;
        data_valid_in1 = 1'b1; packet_in1 = 104'h11; node_in1 = 40'h1;
        data_valid_in2 = 1'b1; packet_in2 = 104'h22; node_in2 = 40'h2;
        repeat (3) cyc();
        chk_reset_outputs("reset_hold");
        RST = 1'b0;
        data_valid_in1 = 1'b0;
        data_valid_in2 = 1'b0;
        repeat (3) cyc();
        chk_reset_outputs("reset_idle");

        // Single result, visible one cycle after sampling, gone one cycle later
        p = 104'h0A0B_0C0D_0E0F_1011_1213_1415_01;
        n = 40'h12_3456_7890;
        exp_q.push_back(mk(p, n, 1'b1, 1'b0));
        drive_a(1'b1, p, n, 1'b1, 1'b0, '0, '0, 1'b0);
        chk("single_valid", res_valid, 1);
        chk("single_fields", {res_packet, res_node, res_matched, res_lane}, {p, n, 1'b1, 1'b0});
        cyc();
        chk("single_empty_after", fifo_empty, 1);

        // Dual arrival: lane 1 ahead of lane 2
        res_ready = 1'b0;
        exp_q.push_back(mk(104'hA1, 40'hA1, 1'b0, 1'b0));
        exp_q.push_back(mk(104'hA2, 40'hA2, 1'b1, 1'b1));
        drive_a(1'b1, 104'hA1, 40'hA1, 1'b0, 1'b1, 104'hA2, 40'hA2, 1'b1);
        chk("dual_count", fifo_count, 2);
        res_ready = 1'b1;
        cyc();
        cyc();
        chk("dual_drained", fifo_empty, 1);
        res_ready = 1'b0;

        // Prefill 7 entries alternating lanes, then both lanes with one slot left
        for (int i = 0; i < 7; i++) begin
            p = {96'hC0, 8'(i)};
            n = {32'hC0, 8'(i)};
            exp_q.push_back(mk(p, n, i[0], i[0]));
            if (i[0]) drive_a(1'b0, '0, '0, 1'b0, 1'b1, p, n, 1'b1);
            else      drive_a(1'b1, p, n, 1'b0, 1'b0, '0, '0, 1'b0);
        end
        chk("prefill_count", fifo_count, 7);
        exp_q.push_back(mk(104'hD1, 40'hD1, 1'b1, 1'b0));
        drive_a(1'b1, 104'hD1, 40'hD1, 1'b1, 1'b1, 104'hD2, 40'hD2, 1'b1);
        chk("partial_count", fifo_count, 8);
        chk("partial_full", fifo_full, 1);
        chk("partial_drop", drop_count, 1);

        // Full with pop: one lane 1 entry accepted per cycle, lane 2 dropped
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk({96'hE1, 8'(i)}, 40'hE1, 1'b0, 1'b0));
            drive_a(1'b1, {96'hE1, 8'(i)}, 40'hE1, 1'b0, 1'b1, {96'hE2, 8'(i)}, 40'hE2, 1'b0);
        end
        chk("fullpop_count", fifo_count, 8);
        chk("fullpop_drop", drop_count, 4);
        repeat (8) cyc();
        chk("fullpop_drained", fifo_empty, 1);
        res_ready = 1'b0;

        // Queue 5 entries, then asynchronous reset mid-cycle
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk({96'hF1, 8'(i)}, 40'hF1, 1'b1, 1'b0));
            exp_q.push_back(mk({96'hF2, 8'(i)}, 40'hF2, 1'b0, 1'b1));
            drive_a(1'b1, {96'hF1, 8'(i)}, 40'hF1, 1'b1, 1'b1, {96'hF2, 8'(i)}, 40'hF2, 1'b0);
        end
        drive_a(1'b1, 104'hF3, 40'hF3, 1'b1, 1'b0, '0, '0, 1'b0);
        chk("midrst_count_before", fifo_count, 5);
        #2;
        RST = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        exp_q.delete();
        cyc();
        RST = 1'b0;

        // Saturation on the 2-bit counter instance: 5 drops hold at 3
        drive_b(1'b1, 1'b1, 8'd0);
        drive_b(1'b1, 1'b1, 8'd1);
        chk("sat_b_count", b_fifo_count, 4);
        chk("sat_b_full", b_fifo_full, 1);
        chk("sat_b_drop0", b_drop_count, 0);
        drive_b(1'b1, 1'b1, 8'd2);
        chk("sat_b_drop2", b_drop_count, 2);
        drive_b(1'b1, 1'b1, 8'd3);
        chk("sat_b_drop4", b_drop_count, 3);
        drive_b(1'b1, 1'b0, 8'd4);
        chk("sat_b_drop5", b_drop_count, 3);
        chk("sat_b_head", {b_res_packet, b_res_lane}, {96'hB1, 8'd0, 1'b0});

        cyc();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
